md5_iter_core: RTL and testbench
================================

# md5_iter_core

Iterative, parametrised MD5 compression core for the brute-force hasher. It holds a 64-byte staging message that the candidate generator patches one byte at a time, snapshots it on `start`, and runs the 64 MD5 rounds over a configurable number of cycles. It returns a configurable-width slice of the digest. Where the fully unrolled pipeline is too large, several of these cores are instantiated side by side to trade area for hashrate.

## Interface
- `UNROLL`, default 1: MD5 rounds evaluated per clock; legal values are 1, 2, 4, 8 and 16. Define `N = 64/UNROLL`.
- `OUT_W`, default 64: output digest width; legal values are 32, 64, 96 and 128.
- `clk` input, 1: clock, all logic on the rising edge.
- `reset` input, 1: synchronous, active-low reset.
- `wr_en` input, 1: write `msbyte_in` into the staging buffer at `offset_in`.
- `offset_in` input, 6: byte address 0..63 (0 = first message byte).
- `msbyte_in` input, 8: byte value to write.
- `start` input, 1: request a hash of the current staging buffer.
- `target_in` input, `OUT_W`: compare value, used only with `MD5_TARGET_CMP_EN`.
- `busy` output, 1: hash in progress; `start` is ignored while high.
- `done` output, 1: one-cycle pulse; `hash_out` is valid.
- `hash_out` output, `OUT_W`: digest slice, held until the next `done`.
- `match` output, 1: `hash_out == target_in`, qualified by `done`.

## Operation
- **Staging buffer:** 64 bytes, writable every cycle, including while `busy`.
- **Word packing:** word i = {byte 4i+3, byte 4i+2, byte 4i+1, byte 4i}, MD5 little-endian.
- **Padding:** the core does none. Software or the generator writes 0x80 and the length bytes.
- **Snapshot:** `start` accepted in IDLE copies staging into the working block. A `wr_en` in the same cycle lands in staging after the copy, so it is not part of this hash.
- **State IDLE:**
  - `busy`=0.
  - On `start`: load A..D with the IV (67452301, efcdab89, 98badcfe, 10325476), clear the round counter, go to RUN.
- **State RUN:**
  - `busy`=1.
  - Each cycle applies UNROLL consecutive standard MD5 rounds (F/G/H/I functions, K table, shift amounts, message index) to A..D.
  - The round counter advances by UNROLL. After the cycle that completes round 63, go to FIN.
- **State FIN:**
  - `busy`=1.
  - Register `digest = {D+IV_D, C+IV_C, B+IV_B, A+IV_A}` (128 bits, A in bits 31:0).
  - `hash_out = digest[127 -: OUT_W]`, so OUT_W=64 gives {D,C}.
  - Pulse `done`, return to IDLE.
- **Arithmetic:** all additions are mod 2^32 and the rotates are 32-bit.
- **Reset (`reset`=0 at a rising edge):**
  - State returns to IDLE; `busy`=0, `done`=0, `match`=0, `hash_out`=0.
  - The staging buffer, the working block and the counter are cleared.
  - A reset during RUN or FIN aborts the hash; no `done` is issued.

## Timing
- **Start acceptance:** `start` is sampled at edge E0, and only if IDLE.
- **Busy:** `busy` rises after E0.
- **Done:** `done` and the new `hash_out` appear after edge E0+N+1, and `busy` falls at the same edge. Latency is 65 cycles at UNROLL=1 and 9 cycles at UNROLL=8.
- **Back-to-back:** `start` asserted in the `done` cycle is accepted, since the state is already IDLE. Throughput is one hash per N+1 cycles.
- **Start while busy:** dropped; it is not queued.
- **`done`:** high exactly one cycle.
- **`hash_out`:** changes only at a `done` edge or on reset.

## Configuration
- **`MD5_TARGET_CMP_EN` defined:**
  - A registered comparator is built.
  - `match` is high in the `done` cycle iff `hash_out == target_in`, with `target_in` sampled at the FIN edge.
  - `match` is 0 otherwise.
- **Not defined:**
  - `match` is tied 0 and `target_in` is unused.
  - No comparator logic is synthesised.
  - The port list is unchanged.

## Test plan
- **Empty string:**
  - Stimulus: UNROLL=1, OUT_W=64; write byte0=0x80, all others 0; pulse `start`.
  - Required response: `done` after exactly 65 edges, `hash_out`=0x7e42f8ec_980980e9.
- **"abc":**
  - Stimulus: UNROLL=4, OUT_W=128; bytes 0..3 = 61 62 63 80, byte56=0x18, rest 0.
  - Required response: `done` after 17 edges, `hash_out`=0x727fe128_7d3f96d6_b04fd23c_98500190.
- **Snapshot isolation:**
  - Stimulus: empty-string setup; write byte0=0x61 in the `start` cycle, then more writes during RUN.
  - Required response: the first result is the empty-string digest; a second `start` hashes the modified buffer.
- **Back-to-back and ignored start:**
  - Stimulus: `start` held high continuously.
  - Required response: `done` every N+1 cycles; the extra `start`s during `busy` have no effect.
- **Reset mid-run:**
  - Stimulus: `reset`=0 for one cycle at round 30.
  - Required response: `busy`=0, `hash_out`=0, no `done`; a subsequent empty-string run completes correctly.
- **Target compare (`MD5_TARGET_CMP_EN`):**
  - Stimulus: `target_in`=0x7e42f8ec_980980e9 with the empty-string run; then `target_in`=0.
  - Required response: `match`=1 with `done` for the first target; `match`=0 for the second. With the macro undefined, `match` stays 0.

Source files
------------

// File: rtl/md5_iter_core.sv
// md5_iter_core: iterative MD5 compression core, UNROLL rounds per clock; `MD5_TARGET_CMP_EN adds a registered target comparator
module md5_iter_core #(
   parameter int UNROLL = 1,
   parameter int OUT_W  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [5:0]       offset_in,
   input  logic [7:0]       msbyte_in,
   input  logic             start,
   input  logic [OUT_W-1:0] target_in,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] hash_out,
   output logic             match
);
   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;
   localparam logic [31:0] K [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };
   // shift amount indexed by {round group, round mod 4}
   localparam logic [4:0] S [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
   };

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state_q, state_d;
   logic [7:0]        stg_q [64];
   logic [31:0]       blk_q [16];
   logic [31:0]       a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
   logic [31:0]       ra, rb, rc, rd;
   logic [5:0]        cnt_q, cnt_d;
   logic [OUT_W-1:0]  hash_q, hash_d;
   logic              done_q, done_d;
   logic              load;
   logic [127:0]      digest;

   function automatic logic [31:0] md5_f(input logic [1:0] g, input logic [31:0] b, c, d);
      return (g == 2'd0) ? ((b & c) | (~b & d)) :
             (g == 2'd1) ? ((b & d) | (c & ~d)) :
             (g == 2'd2) ? (b ^ c ^ d) : (c ^ (b | ~d));
   endfunction

   // message word index; the mod-16 reduction falls out of 4-bit arithmetic
   function automatic logic [3:0] md5_g(input logic [5:0] r);
      return (r[5:4] == 2'd0) ? r[3:0] :
             (r[5:4] == 2'd1) ? r[3:0] * 4'd5 + 4'd1 :
             (r[5:4] == 2'd2) ? r[3:0] * 4'd3 + 4'd5 : r[3:0] * 4'd7;
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (6'd32 - 6'(s)));
   endfunction

   assign digest   = {d_q + IV_D, c_q + IV_C, b_q + IV_B, a_q + IV_A};
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign hash_out = hash_q;

   // UNROLL chained MD5 rounds starting at the current round counter
   always_comb begin
      logic [5:0]  r;
      logic [31:0] t;
      r  = cnt_q;
      t  = '0;
      ra = a_q;
      rb = b_q;
      rc = c_q;
      rd = d_q;
      for (int u = 0; u < UNROLL; u++) begin
         r  = cnt_q + 6'(u);
         t  = ra + md5_f(r[5:4], rb, rc, rd) + K[r] + blk_q[md5_g(r)];
         ra = rd;
         rd = rc;
         rc = rb;
         rb = rb + rotl(t, S[{r[5:4], r[1:0]}]);
      end
   end

   // next state, working-variable update and result capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      hash_d  = hash_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            load    = 1'b1;
            cnt_d   = '0;
            a_d     = IV_A;
            b_d     = IV_B;
            c_d     = IV_C;
            d_d     = IV_D;
         end
         RUN: begin
            a_d     = ra;
            b_d     = rb;
            c_d     = rc;
            d_d     = rd;
            cnt_d   = cnt_q + 6'(UNROLL);
            state_d = (cnt_q == 6'(64 - UNROLL)) ? FIN : RUN;
         end
         FIN: begin
            hash_d  = OUT_W'(digest >> (128 - OUT_W));
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // control, working variables, snapshot block and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         hash_q  <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         hash_q  <= hash_d;
         done_q  <= done_d;
         if (load)
            for (int i = 0; i < 16; i++)
               blk_q[i] <= {stg_q[4*i+3], stg_q[4*i+2], stg_q[4*i+1], stg_q[4*i]};
      end
   end

   // staging buffer; the snapshot reads the pre-write contents
   always_ff @(posedge clk) begin
      if (!reset)
         for (int i = 0; i < 64; i++) stg_q[i] <= '0;
      else if (wr_en)
         stg_q[offset_in] <= msbyte_in;
   end

`ifdef MD5_TARGET_CMP_EN
   logic match_q;

   // compare the fresh digest slice with the target at the FIN edge
   always_ff @(posedge clk) begin
      if (!reset)
         match_q <= 1'b0;
      else
         match_q <= (state_q == FIN) && (hash_d == target_in);
   end

   assign match = match_q;
`else
   logic unused_target;

   assign unused_target = ^target_in;
   assign match         = 1'b0;
`endif
endmodule

// File: tb/tb_md5_iter_core.sv
// tb_md5_iter_core: directed MD5 vectors on UNROLL=1/OUT_W=64 and UNROLL=4/OUT_W=128 instances
module tb_md5_iter_core;
   localparam logic [63:0]  EMPTY64 = 64'h7e42f8ec_980980e9;
   localparam logic [63:0]  A64     = 64'h61267769_e299c331;
   localparam logic [127:0] ABC128  = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
`ifdef MD5_TARGET_CMP_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         wr1 = 1'b0, st1 = 1'b0, wr4 = 1'b0, st4 = 1'b0;
   logic [5:0]   off1 = '0, off4 = '0;
   logic [7:0]   byte1 = '0, byte4 = '0;
   logic [63:0]  tgt1 = '0;
   logic [127:0] tgt4 = '0;
   logic         busy1, done1, match1, busy4, done4, match4;
   logic [63:0]  hash1;
   logic [127:0] hash4;
   int           cyc = 0;
   int           n_tests = 0;
   int           n_fail = 0;

   md5_iter_core #(.UNROLL(1), .OUT_W(64)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr1), .offset_in(off1), .msbyte_in(byte1),
      .start(st1), .target_in(tgt1), .busy(busy1), .done(done1), .hash_out(hash1), .match(match1)
   );

   md5_iter_core #(.UNROLL(4), .OUT_W(128)) u4 (
      .clk(clk), .reset(reset), .wr_en(wr4), .offset_in(off4), .msbyte_in(byte4),
      .start(st4), .target_in(tgt4), .busy(busy4), .done(done4), .hash_out(hash4), .match(match4)
   );

   always #5 clk = ~clk;

   // posedge counter used to measure start-to-done latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wb1(input logic [5:0] o, input logic [7:0] b);
      wr1 = 1'b1; off1 = o; byte1 = b;
      @(negedge clk);
      wr1 = 1'b0;
   endtask

   task automatic wb4(input logic [5:0] o, input logic [7:0] b);
      wr4 = 1'b1; off4 = o; byte4 = b;
      @(negedge clk);
      wr4 = 1'b0;
   endtask

   // pulse start for one edge (E0) and return the edge count at E0
   task automatic go1(output int e0);
      st1 = 1'b1;
      @(negedge clk);
      e0 = cyc;
      st1 = 1'b0;
   endtask

   // wait (bounded) for done on u1, then check latency, slice and match
   task automatic wait1(input int e0, input string tag, input int lat, input logic [63:0] exp);
      while (!done1 && cyc - e0 <= 200) @(negedge clk);
      check({tag, " latency"}, 128'(cyc - e0), 128'(lat));
      check({tag, " hash"}, 128'(hash1), 128'(exp));
      check({tag, " match"}, 128'(match1), 128'(CMP && (tgt1 == exp)));
   endtask

   initial begin
      int e0;
      int ndone;
      repeat (2) @(negedge clk);
      check("reset busy", 128'(busy1), 128'(0));
      check("reset done", 128'(done1), 128'(0));
      check("reset hash", 128'(hash1), 128'(0));
      check("reset match", 128'(match1), 128'(0));
      reset = 1'b1;
      @(negedge clk);

      // empty string, UNROLL=1: 65 edges from E0 to done
      wb1(6'd0, 8'h80);
      go1(e0);
      check("empty busy", 128'(busy1), 128'(1));
      wait1(e0, "empty", 65, EMPTY64);
      @(negedge clk);
      check("empty done pulse", 128'(done1), 128'(0));
      check("empty busy after", 128'(busy1), 128'(0));
      check("empty hash held", 128'(hash1), 128'(EMPTY64));

      // "abc", UNROLL=4: 17 edges
      wb4(6'd0, 8'h61);
      wb4(6'd1, 8'h62);
      wb4(6'd2, 8'h63);
      wb4(6'd3, 8'h80);
      wb4(6'd56, 8'h18);
      st4 = 1'b1;
      @(negedge clk);
      e0 = cyc;
      st4 = 1'b0;
      while (!done4 && cyc - e0 <= 200) @(negedge clk);
      check("abc latency", 128'(cyc - e0), 128'(17));
      check("abc hash", hash4, ABC128);
      check("abc match", 128'(match4), 128'(0));

      // snapshot isolation: byte0 write in the start cycle and later writes miss this hash
      st1 = 1'b1; wr1 = 1'b1; off1 = 6'd0; byte1 = 8'h61;
      @(negedge clk);
      e0 = cyc;
      st1 = 1'b0; off1 = 6'd1; byte1 = 8'h80;
      @(negedge clk);
      off1 = 6'd56; byte1 = 8'h08;
      @(negedge clk);
      wr1 = 1'b0;
      wait1(e0, "snap first", 65, EMPTY64);
      go1(e0);
      wait1(e0, "snap second", 65, A64);

      // back to empty string, then start held high: accepted at the edge ending each done cycle
      wb1(6'd0, 8'h80);
      wb1(6'd1, 8'h00);
      wb1(6'd56, 8'h00);
      tgt1 = EMPTY64;
      st1 = 1'b1;
      @(negedge clk);
      e0 = cyc;
      wait1(e0, "b2b first", 65, EMPTY64);
      for (int k = 0; k < 2; k++) begin
         e0 = cyc;
         @(negedge clk);
         check("b2b restart busy", 128'(busy1), 128'(1));
         wait1(e0, "b2b next", 66, EMPTY64);
      end
      st1 = 1'b0;
      @(negedge clk);
      check("b2b stop busy", 128'(busy1), 128'(0));

      // target compare with a non-matching target
      tgt1 = '0;
      go1(e0);
      wait1(e0, "target zero", 65, EMPTY64);

      // reset mid-run aborts and clears everything, including staging
      go1(e0);
      repeat (29) @(negedge clk);
      check("midrun busy", 128'(busy1), 128'(1));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort busy", 128'(busy1), 128'(0));
      check("abort hash", 128'(hash1), 128'(0));
      check("abort done", 128'(done1), 128'(0));
      ndone = 0;
      repeat (80) begin
         @(negedge clk);
         if (done1) ndone++;
      end
      check("abort no done", 128'(ndone), 128'(0));
      wb1(6'd0, 8'h80);
      tgt1 = EMPTY64;
      go1(e0);
      wait1(e0, "after reset", 65, EMPTY64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
